piso_serializer: RTL

//  Parallel-in, serial-out transmitter: the sending end for the team's serial shift-register

---
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/piso_serializer_if.sv
// Load/serial-output bundle for piso_serializer: the master drives words in,
// the slave (the serializer) drives the handshake ready and the serial line.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  din, load_valid,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a valid/ready load side and zero-gap framing.
// Optional trailing even-parity bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`else
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
`endif
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_busy;
    logic             r_done;
`ifdef PISO_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_sout_nxt;
    logic             w_valid_nxt;
    logic             w_done_nxt;
    logic             w_last_bit;
    logic             w_final;
    logic             w_ready;
    logic             w_accept;

    // r_cnt indexes the data bit currently on the line; the final cycle may take a new word
    assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == LAST);
`ifdef PISO_PARITY_EN
    assign w_final    = (r_state == S_PARITY);
`else
    assign w_final    = w_last_bit;
`endif
    assign w_ready    = !rst && ((r_state == S_IDLE) || w_final);
    assign w_accept   = bus.load_valid && w_ready;

    // Next-state and next-output computation
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_sout_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
        w_par_nxt   = r_par;
`endif
        if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = CW'(0);
            w_valid_nxt = 1'b1;
`ifdef PISO_PARITY_EN
            w_par_nxt   = ^bus.din;
`endif
            if (LSB_FIRST != 0) begin
                w_sout_nxt  = bus.din[0];
                w_shift_nxt = bus.din >> 1;
            end else begin
                w_sout_nxt  = bus.din[WIDTH-1];
                w_shift_nxt = bus.din << 1;
            end
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (!w_last_bit) begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                        w_valid_nxt = 1'b1;
`ifndef PISO_PARITY_EN
                        w_done_nxt  = (r_cnt == LAST_M1);
`endif
                        if (LSB_FIRST != 0) begin
                            w_sout_nxt  = r_shift[0];
                            w_shift_nxt = r_shift >> 1;
                        end else begin
                            w_sout_nxt  = r_shift[WIDTH-1];
                            w_shift_nxt = r_shift << 1;
                        end
                    end else begin
`ifdef PISO_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_sout_nxt  = r_par;
                        w_valid_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                S_PARITY: w_state_nxt = S_IDLE;
`endif
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= {WIDTH{1'b0}};
            r_cnt        <= CW'(0);
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sout       <= w_sout_nxt;
            r_sout_valid <= w_valid_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= w_done_nxt;
`ifdef PISO_PARITY_EN
            r_par        <= w_par_nxt;
`endif
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule
